// File: rtl/glb_pkg.sv
// Shared constants and types for the global-buffer bank responder.
// Port ids, default widths and the pending-request slot record.
package glb_pkg;

    localparam int PORT_IACT = 0;
    localparam int PORT_WGHT = 1;

    localparam int DEF_DATA_BITWIDTH     = 16;
    localparam int DEF_ADDR_BITWIDTH_GLB = 10;

    // Slot address is stored at a fixed maximum width; users cast it to their own width.
    localparam int GLB_ADDR_MAX = 32;

    typedef struct packed {
        logic                    valid;
        logic [GLB_ADDR_MAX-1:0] addr;
    } pend_slot_t;

endpackage

// File: rtl/glb_bank_responder_if.sv
// Bus bundle between the iact/weight/psum routers (master) and the GLB bank (slave).
// Handshake: req/write_en are single-cycle strobes with no backpressure; enable_o pulses once with data_o valid.
interface glb_bank_responder_if #(
    parameter int DATA_BITWIDTH     = glb_pkg::DEF_DATA_BITWIDTH,
    parameter int ADDR_BITWIDTH_GLB = glb_pkg::DEF_ADDR_BITWIDTH_GLB
);
    logic                         iact_req_read;
    logic [ADDR_BITWIDTH_GLB-1:0] iact_addr_read;
    logic [DATA_BITWIDTH-1:0]     iact_data_o;
    logic                         iact_enable_o;

    logic                         wght_req_read;
    logic [ADDR_BITWIDTH_GLB-1:0] wght_addr_read;
    logic [DATA_BITWIDTH-1:0]     wght_data_o;
    logic                         wght_enable_o;

    logic                         psum_write_en;
    logic [ADDR_BITWIDTH_GLB-1:0] psum_w_addr;
    logic [DATA_BITWIDTH-1:0]     psum_w_data;
    logic                         psum_accum;

    logic                         iact_overflow;
    logic                         wght_overflow;
    logic                         dbg_rr_ptr_o;

    modport master (
        output iact_req_read, iact_addr_read, wght_req_read, wght_addr_read,
        output psum_write_en, psum_w_addr, psum_w_data, psum_accum,
        input  iact_data_o, iact_enable_o, wght_data_o, wght_enable_o,
        input  iact_overflow, wght_overflow, dbg_rr_ptr_o
    );

    modport slave (
        input  iact_req_read, iact_addr_read, wght_req_read, wght_addr_read,
        input  psum_write_en, psum_w_addr, psum_w_data, psum_accum,
        output iact_data_o, iact_enable_o, wght_data_o, wght_enable_o,
        output iact_overflow, wght_overflow, dbg_rr_ptr_o
    );
endinterface

// File: rtl/glb_rr_arb2.sv
// Two-input round-robin arbiter: the pointer names the port that wins the next contested cycle.
// ptr_o exposes the pointer for observation.
module glb_rr_arb2
    import glb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    output logic [1:0] grant_o,
    output logic       ptr_o
);
    logic ptr_q, ptr_d;

    always_comb begin
        grant_o = req_i;
        ptr_d   = ptr_q;
        if (req_i == 2'b11) begin
            grant_o        = 2'b00;
            grant_o[ptr_q] = 1'b1;
            ptr_d          = ~ptr_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= 1'(PORT_IACT);
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;
endmodule

// File: rtl/glb_bank_responder.sv
// Global-buffer bank: two read ports sharing one arbitrated read path with one-entry
// pending slots, and a two-stage psum write/accumulate pipeline into the same array.
module glb_bank_responder
    import glb_pkg::*;
#(
    parameter int DATA_BITWIDTH     = DEF_DATA_BITWIDTH,
    parameter int ADDR_BITWIDTH_GLB = DEF_ADDR_BITWIDTH_GLB
) (
    input logic                 clk,
    input logic                 reset,
    glb_bank_responder_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_BITWIDTH_GLB;

    logic [DATA_BITWIDTH-1:0]     mem [DEPTH];

    logic [1:0]                   new_req;
    logic [ADDR_BITWIDTH_GLB-1:0] new_addr [2];
    logic [1:0]                   port_req;
    logic [1:0]                   grant;
    logic [ADDR_BITWIDTH_GLB-1:0] serve_addr [2];
    pend_slot_t                   slot_q [2];
    pend_slot_t                   slot_d [2];
    logic [1:0]                   en_q;
    logic [DATA_BITWIDTH-1:0]     data_q [2];
    logic [1:0]                   ovf_q, ovf_d;
    logic                         rr_ptr;
    logic [ADDR_BITWIDTH_GLB-1:0] rd_addr;
    logic [DATA_BITWIDTH-1:0]     rd_data;

    logic                         s1_valid_q;
    logic                         s1_accum_q;
    logic [ADDR_BITWIDTH_GLB-1:0] s1_addr_q;
    logic [DATA_BITWIDTH-1:0]     s1_data_q;
    logic [DATA_BITWIDTH-1:0]     wr_data;

    assign new_req[PORT_IACT]  = bus.iact_req_read;
    assign new_req[PORT_WGHT]  = bus.wght_req_read;
    assign new_addr[PORT_IACT] = bus.iact_addr_read;
    assign new_addr[PORT_WGHT] = bus.wght_addr_read;

    // A valid pending slot always takes precedence over a fresh request on the same port.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            port_req[p]   = slot_q[p].valid | new_req[p];
            serve_addr[p] = slot_q[p].valid ? ADDR_BITWIDTH_GLB'(slot_q[p].addr) : new_addr[p];
        end
    end

    glb_rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req_i   (port_req),
        .grant_o (grant),
        .ptr_o   (rr_ptr)
    );

    assign rd_addr = grant[PORT_WGHT] ? serve_addr[PORT_WGHT] : serve_addr[PORT_IACT];
    assign rd_data = mem[rd_addr];

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            slot_d[p] = slot_q[p];
            ovf_d[p]  = ovf_q[p];
            if (grant[p]) begin
                // Served from the slot: a same-cycle request refills it; otherwise it empties.
                slot_d[p].valid = slot_q[p].valid & new_req[p];
                if (slot_q[p].valid && new_req[p]) begin
                    slot_d[p].addr = GLB_ADDR_MAX'(new_addr[p]);
                end
            end else if (new_req[p]) begin
                if (slot_q[p].valid) begin
                    ovf_d[p] = 1'b1;
                end else begin
                    slot_d[p].valid = 1'b1;
                    slot_d[p].addr  = GLB_ADDR_MAX'(new_addr[p]);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                slot_q[p] <= '0;
                data_q[p] <= '0;
            end
            en_q       <= '0;
            ovf_q      <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                slot_q[p] <= slot_d[p];
                if (grant[p]) begin
                    data_q[p] <= rd_data;
                end
            end
            en_q       <= grant;
            ovf_q      <= ovf_d;
            s1_valid_q <= bus.psum_write_en;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.psum_write_en) begin
            s1_addr_q  <= bus.psum_w_addr;
            s1_data_q  <= bus.psum_w_data;
            s1_accum_q <= bus.psum_accum;
        end
    end

    // Stage 2 reads the stored word in the same cycle it writes, so consecutive
    // accumulates to one address always see the prior result.
    assign wr_data = s1_accum_q ? (mem[s1_addr_q] + s1_data_q) : s1_data_q;

    always_ff @(posedge clk) begin
        if (s1_valid_q) begin
            mem[s1_addr_q] <= wr_data;
        end
    end

    assign bus.iact_enable_o = en_q[PORT_IACT];
    assign bus.wght_enable_o = en_q[PORT_WGHT];
    assign bus.iact_data_o   = data_q[PORT_IACT];
    assign bus.wght_data_o   = data_q[PORT_WGHT];
    assign bus.iact_overflow = ovf_q[PORT_IACT];
    assign bus.wght_overflow = ovf_q[PORT_WGHT];
    assign bus.dbg_rr_ptr_o  = rr_ptr;
endmodule

// File: tb/tb_glb_bank_responder.sv
// Directed bench for glb_bank_responder: preload via psum writes, then reads, contention,
// overflow, accumulate, read/write collision and mid-operation reset, with an expected-data scoreboard.
module tb_glb_bank_responder;
    localparam int DW = 16;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    glb_bank_responder_if #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH_GLB(AW)) bus ();

    glb_bank_responder #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH_GLB(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DW-1:0] exp_iact_q [$];
    logic [DW-1:0] exp_wght_q [$];
    logic [DW-1:0] mdl [1<<AW];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive_reqs(input logic ir, input logic [AW-1:0] ia, input logic wr, input logic [AW-1:0] wa);
        bus.iact_req_read  = ir;
        bus.iact_addr_read = ia;
        bus.wght_req_read  = wr;
        bus.wght_addr_read = wa;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic acc);
        bus.psum_write_en = 1'b1;
        bus.psum_w_addr   = a;
        bus.psum_w_data   = d;
        bus.psum_accum    = acc;
        mdl[a] = acc ? mdl[a] + d : d;
        tick();
        bus.psum_write_en = 1'b0;
        bus.psum_accum    = 1'b0;
    endtask

    task automatic iact_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        drive_reqs(1'b1, a, 1'b0, '0);
        exp_iact_q.push_back(exp);
        tick();
        check({tag, "_en"}, bus.iact_enable_o, 1);
        check({tag, "_data"}, bus.iact_data_o, exp);
        drive_reqs(1'b0, '0, 1'b0, '0);
    endtask

    // Scoreboard: every enable pulse must match the oldest expected word on that port.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (bus.iact_enable_o === 1'b1) begin
                if (exp_iact_q.size() == 0) check("iact_unexpected_enable", bus.iact_enable_o, 0);
                else check("iact_sb_data", bus.iact_data_o, exp_iact_q.pop_front());
            end
            if (bus.wght_enable_o === 1'b1) begin
                if (exp_wght_q.size() == 0) check("wght_unexpected_enable", bus.wght_enable_o, 0);
                else check("wght_sb_data", bus.wght_data_o, exp_wght_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drive_reqs(1'b0, '0, 1'b0, '0);
        bus.psum_write_en = 1'b0;
        bus.psum_w_addr   = '0;
        bus.psum_w_data   = '0;
        bus.psum_accum    = 1'b0;
        tick();
        tick();
        check("rst_iact_en", bus.iact_enable_o, 0);
        check("rst_wght_en", bus.wght_enable_o, 0);
        check("rst_iact_data", bus.iact_data_o, 0);
        check("rst_wght_data", bus.wght_data_o, 0);
        check("rst_iact_ovf", bus.iact_overflow, 0);
        check("rst_wght_ovf", bus.wght_overflow, 0);
        check("rst_ptr", bus.dbg_rr_ptr_o, 0);
        reset = 1'b0;
        tick();

        // Preload through the overwrite path.
        do_write(10'd5, 16'h1234, 1'b0);
        do_write(10'd3, 16'hAAAA, 1'b0);
        do_write(10'd4, 16'hBBBB, 1'b0);
        do_write(10'd9, 16'h0011, 1'b0);
        do_write(10'd7, 16'd10, 1'b0);
        do_write(10'd20, 16'hFFFF, 1'b0);
        for (int i = 10; i < 16; i++) do_write(AW'(i), 16'h1000 + DW'(i), 1'b0);
        tick();
        tick();

        // Uncontested read, then hold of data after the pulse.
        drive_reqs(1'b1, 10'd5, 1'b0, '0);
        exp_iact_q.push_back(16'h1234);
        tick();
        check("uncont_iact_en", bus.iact_enable_o, 1);
        check("uncont_iact_data", bus.iact_data_o, 16'h1234);
        check("uncont_wght_en", bus.wght_enable_o, 0);
        drive_reqs(1'b0, '0, 1'b0, '0);
        tick();
        check("uncont_en_single", bus.iact_enable_o, 0);
        check("uncont_data_hold", bus.iact_data_o, 16'h1234);

        // Contention: iact first, wght next; repeat contention then favours wght.
        drive_reqs(1'b1, 10'd3, 1'b1, 10'd4);
        exp_iact_q.push_back(16'hAAAA);
        exp_wght_q.push_back(16'hBBBB);
        tick();
        check("cont1_iact_en", bus.iact_enable_o, 1);
        check("cont1_wght_en", bus.wght_enable_o, 0);
        check("cont1_ptr", bus.dbg_rr_ptr_o, 1);
        drive_reqs(1'b0, '0, 1'b0, '0);
        tick();
        check("cont1_wght_late_en", bus.wght_enable_o, 1);
        check("cont1_wght_late_data", bus.wght_data_o, 16'hBBBB);
        check("cont1_iact_idle", bus.iact_enable_o, 0);
        drive_reqs(1'b1, 10'd4, 1'b1, 10'd3);
        exp_wght_q.push_back(16'hAAAA);
        exp_iact_q.push_back(16'hBBBB);
        tick();
        check("cont2_wght_en", bus.wght_enable_o, 1);
        check("cont2_iact_en", bus.iact_enable_o, 0);
        check("cont2_ptr", bus.dbg_rr_ptr_o, 0);
        drive_reqs(1'b0, '0, 1'b0, '0);
        tick();
        check("cont2_iact_late_en", bus.iact_enable_o, 1);
        check("cont2_iact_late_data", bus.iact_data_o, 16'hBBBB);

        // Overflow: both ports pulse three cycles; the third wght request is dropped.
        drive_reqs(1'b1, 10'd10, 1'b1, 10'd13);
        exp_iact_q.push_back(16'h100A);
        exp_iact_q.push_back(16'h100B);
        exp_iact_q.push_back(16'h100C);
        exp_wght_q.push_back(16'h100D);
        exp_wght_q.push_back(16'h100E);
        tick();
        check("ovf_c1_iact_en", bus.iact_enable_o, 1);
        check("ovf_c1_wght_ovf", bus.wght_overflow, 0);
        drive_reqs(1'b1, 10'd11, 1'b1, 10'd14);
        tick();
        check("ovf_c2_wght_data", bus.wght_data_o, 16'h100D);
        check("ovf_c2_wght_ovf", bus.wght_overflow, 0);
        drive_reqs(1'b1, 10'd12, 1'b1, 10'd15);
        tick();
        check("ovf_c3_iact_data", bus.iact_data_o, 16'h100B);
        check("ovf_c3_wght_ovf", bus.wght_overflow, 1);
        check("ovf_c3_iact_ovf", bus.iact_overflow, 0);
        drive_reqs(1'b0, '0, 1'b0, '0);
        tick();
        check("ovf_c4_wght_data", bus.wght_data_o, 16'h100E);
        tick();
        check("ovf_c5_iact_data", bus.iact_data_o, 16'h100C);
        for (int i = 0; i < 4; i++) tick();
        check("ovf_sticky", bus.wght_overflow, 1);
        check("ovf_drain_iact", exp_iact_q.size(), 0);
        check("ovf_drain_wght", exp_wght_q.size(), 0);

        // Accumulate: three back-to-back adds, then a wrapping add.
        do_write(10'd7, 16'd5, 1'b1);
        do_write(10'd7, 16'd5, 1'b1);
        do_write(10'd7, 16'd5, 1'b1);
        do_write(10'd20, 16'd2, 1'b1);
        tick();
        tick();
        iact_read("acc_sum", 10'd7, 16'd25);
        iact_read("acc_wrap", 10'd20, 16'h0001);

        // Collision: stage-2 write to addr 9 in the same cycle as its grant.
        bus.psum_write_en = 1'b1;
        bus.psum_w_addr   = 10'd9;
        bus.psum_w_data   = 16'h00FF;
        bus.psum_accum    = 1'b0;
        mdl[9] = 16'h00FF;
        tick();
        bus.psum_write_en = 1'b0;
        drive_reqs(1'b1, 10'd9, 1'b0, '0);
        exp_iact_q.push_back(16'h0011);
        tick();
        check("coll_old_data", bus.iact_data_o, 16'h0011);
        exp_iact_q.push_back(16'h00FF);
        tick();
        check("coll_new_data", bus.iact_data_o, 16'h00FF);
        drive_reqs(1'b0, '0, 1'b0, '0);
        tick();

        // Reset with a pending wght slot and an accumulate sitting in stage 1.
        drive_reqs(1'b1, 10'd5, 1'b1, 10'd4);
        bus.psum_write_en = 1'b1;
        bus.psum_w_addr   = 10'd7;
        bus.psum_w_data   = 16'd100;
        bus.psum_accum    = 1'b1;
        tick();
        check("mid_pre_iact_en", bus.iact_enable_o, 1);
        check("mid_pre_ptr", bus.dbg_rr_ptr_o, 1);
        drive_reqs(1'b0, '0, 1'b0, '0);
        bus.psum_write_en = 1'b0;
        bus.psum_accum    = 1'b0;
        reset = 1'b1;
        #1;
        check("mid_rst_iact_en", bus.iact_enable_o, 0);
        check("mid_rst_iact_data", bus.iact_data_o, 0);
        check("mid_rst_wght_data", bus.wght_data_o, 0);
        check("mid_rst_wght_ovf", bus.wght_overflow, 0);
        check("mid_rst_ptr", bus.dbg_rr_ptr_o, 0);
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_post_wght_en", bus.wght_enable_o, 0);
            check("mid_post_iact_en", bus.iact_enable_o, 0);
        end
        iact_read("mid_mem_kept", 10'd7, mdl[7]);
        check("mid_mem_kept_lit", bus.iact_data_o, 16'd25);
        drive_reqs(1'b1, 10'd3, 1'b1, 10'd4);
        exp_iact_q.push_back(16'hAAAA);
        exp_wght_q.push_back(16'hBBBB);
        tick();
        check("mid_ptr_iact_first", bus.iact_enable_o, 1);
        check("mid_ptr_wght_wait", bus.wght_enable_o, 0);
        drive_reqs(1'b0, '0, 1'b0, '0);
        tick();
        check("mid_ptr_wght_next", bus.wght_enable_o, 1);
        tick();
        tick();
        check("end_drain_iact", exp_iact_q.size(), 0);
        check("end_drain_wght", exp_wght_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
